// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Holds the state encoding, the default operand width and the counter
// width helper used to size the slice counter.
package serial_add_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_WIDTH = 8;

    // State encoding values, kept as localparams so other blocks can refer
    // to the raw codes if they ever need to
    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    // Ceiling log2 with a floor of one bit, so a two-bit operation still
    // gets a usable one-bit slice counter
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << bits) < value) begin
                bits = bits + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/a_full_adder.sv
// Gate-level one-bit full-adder cell.
// Purely combinational; the sequencer registers both outputs before use,
// so the gate delays never reach another cell in the same cycle.
module a_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic halfSum;
    logic generateBit;
    logic propagateBit;

    // First half adder: propagate term and generate term from the operands
    assign halfSum      = a_i ^ b_i;
    assign generateBit  = a_i & b_i;

    // Second half adder: fold in the incoming carry
    assign s_o          = halfSum ^ ci_i;
    assign propagateBit = halfSum & ci_i;

    // Carry out is set either by the operands alone or by a propagated carry
    assign co_o         = generateBit | propagateBit;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer around a single shared full-adder cell.
// The operation runs LSB first, one bit slice per clock, with the carry
// held in a register between slices.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub port and turns the
// block into an adder/subtractor (A - B via inverted B and a carry seed of 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] aSr_q;
    logic [WIDTH-1:0] bSr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             cy_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             cOut_q;
    logic             overflow_q;

    logic             subSeed;
    logic             faB;
    logic             faSum;
    logic             faCo;

`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q;

    // Subtraction inverts every B bit and seeds the carry with one, which
    // is two's complement negation folded into the serial add
    assign subSeed = sub;
    assign faB     = bSr_q[0] ^ sub_q;
`else
    // Addition only: carry always starts clear and B goes straight through
    assign subSeed = 1'b0;
    assign faB     = bSr_q[0];
`endif

    // The one and only adder cell, reused for every bit position in turn
    a_full_adder u_fa (
        .a_i  (aSr_q[0]),
        .b_i  (faB),
        .ci_i (cy_q),
        .s_o  (faSum),
        .co_o (faCo)
    );

    // Next slice index; it is only consumed while running, and the last
    // slice leaves RUN before any wrap could matter
    always_comb begin
        cnt_d = cnt_q + CW'(1);
    end

    // Sequencer: accepts a start in IDLE or DONE, walks WIDTH slices through
    // the shared adder, then raises done for one cycle with the flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            aSr_q      <= '0;
            bSr_q      <= '0;
            cnt_q      <= '0;
            cy_q       <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cOut_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        aSr_q   <= op_a;
                        bSr_q   <= op_b;
                        cnt_q   <= '0;
                        cy_q    <= subSeed;
`ifdef SERIAL_ADD_SUB_EN
                        sub_q   <= sub;
`endif
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    result_q <= {faSum, result_q[WIDTH-1:1]};
                    cy_q     <= faCo;
                    aSr_q    <= aSr_q >> 1;
                    bSr_q    <= bSr_q >> 1;
                    cnt_q    <= cnt_d;
                    if (cnt_q == LAST) begin
                        // On the MSB slice cy_q is the carry into the MSB and
                        // faCo the carry out; their XOR is signed overflow
                        cOut_q     <= faCo;
                        overflow_q <= cy_q ^ faCo;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign c_out    = cOut_q;
    assign overflow = overflow_q;

endmodule
